// File: rtl/regfile_pkg.sv
// Shared defines for the integer pipeline register file: control literals,
// bus widths and architectural register counts.
package regfile_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'b00000;

  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [31:0]           RegBus;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register-file read port. Applies, in priority order:
// reset forces zero, index 0 reads zero, same-cycle write bypass, enable gate.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              rst,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] reg_val,
  output logic [DATA_W-1:0] rdata
);

  // Read mux: zero/bypass/array/disable selection
  always_comb begin
    rdata = '0;
    if (rst == RstEnable) begin
      rdata = '0;
    end else if (raddr == '0) begin
      // $zero stays zero even while a write to it is in flight
      rdata = '0;
    end else if ((re == ReadEnable) && (we == WriteEnable) && (raddr == waddr)) begin
      rdata = wdata;
    end else if (re == ReadEnable) begin
      rdata = reg_val;
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile.sv
// MIPS general-purpose register file: one write port fed from MEM/WB, two
// combinational read ports for decode with same-cycle write bypass.
// Optional build macro REGFILE_DBG_PORT_EN adds an always-enabled debug read
// port (dbg_raddr/dbg_rdata) and a committed-write counter (dbg_wr_cnt).
module regfile
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RegNum,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        re1,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1,
  output logic [DATA_W-1:0]           rdata1,
  input  logic                        re2,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2,
  output logic [DATA_W-1:0]           rdata2
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_raddr,
  output logic [DATA_W-1:0]           dbg_rdata,
  output logic [31:0]                 dbg_wr_cnt
`endif
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_commit;

  // A write retires only outside reset and never into $zero
  assign wr_commit = (rst != RstEnable) && (we == WriteEnable) && (waddr != '0);

  // Next-state array: reset clears everything, otherwise apply the retiring write
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (rst == RstEnable) ? '0 : regs_q[i];
    end
    if (wr_commit) begin
      regs_d[waddr] = wdata;
    end
  end

  // Architectural register state
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  regfile_rd_port #(.DATA_W(DATA_W), .AW(AW)) u_rd1 (
    .rst     (rst),
    .re      (re1),
    .raddr   (raddr1),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .reg_val (regs_q[raddr1]),
    .rdata   (rdata1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .AW(AW)) u_rd2 (
    .rst     (rst),
    .re      (re2),
    .raddr   (raddr2),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .reg_val (regs_q[raddr2]),
    .rdata   (rdata2)
  );

`ifdef REGFILE_DBG_PORT_EN
  logic [31:0] dbg_wr_cnt_q;
  logic [31:0] dbg_wr_cnt_d;

  regfile_rd_port #(.DATA_W(DATA_W), .AW(AW)) u_rd_dbg (
    .rst     (rst),
    .re      (ReadEnable),
    .raddr   (dbg_raddr),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .reg_val (regs_q[dbg_raddr]),
    .rdata   (dbg_rdata)
  );

  // Committed-write count, wraps naturally at 2^32
  always_comb begin
    dbg_wr_cnt_d = dbg_wr_cnt_q;
    if (rst == RstEnable) begin
      dbg_wr_cnt_d = '0;
    end else if (wr_commit) begin
      dbg_wr_cnt_d = dbg_wr_cnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    dbg_wr_cnt_q <= dbg_wr_cnt_d;
  end

  assign dbg_wr_cnt = dbg_wr_cnt_q;
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for the register file.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
`ifdef REGFILE_DBG_PORT_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [31:0] dbg_wr_cnt;
`endif

  int n_cmp;
  int n_err;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .dbg_wr_cnt (dbg_wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_raddr = '0;
`endif
    tick();
    rst = 1'b0;
    #1;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd30;
    #1;
    chk("post_reset_r9", rdata1, 32'h0);
    chk("post_reset_r30", rdata2, 32'h0);

    // Preload r1..r31
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
    raddr1 = 5'd1; raddr2 = 5'd31;
    #1;
    chk("preload_r1", rdata1, 32'hA5A5_0001);
    chk("preload_r31", rdata2, 32'hA5A5_001F);

    // Reset forces zero on reads while asserted, then clears the array
    rst = 1'b1;
    #1;
    chk("rst_rd1", rdata1, 32'h0);
    chk("rst_rd2", rdata2, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      chk($sformatf("clr_p1_r%0d", i), rdata1, 32'h0);
      chk($sformatf("clr_p2_r%0d", 31 - i), rdata2, 32'h0);
    end

    // Basic write then read; disabled port returns zero
    wr(5'd5, 32'hDEAD_BEEF);
    raddr1 = 5'd5; re1 = 1'b1; raddr2 = 5'd5; re2 = 1'b0;
    #1;
    chk("wr_r5_p1", rdata1, 32'hDEAD_BEEF);
    chk("wr_r5_p2_dis", rdata2, 32'h0);

    // Bypass on both ports in the write cycle
    re2 = 1'b1;
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    chk("byp_p1", rdata1, 32'h1234_5678);
    chk("byp_p2", rdata2, 32'h1234_5678);
    re2 = 1'b0;
    #1;
    chk("byp_p2_dis", rdata2, 32'h0);
    re2 = 1'b1;
    tick();
    we = 1'b0; wdata = 32'h0BAD_0BAD;
    #1;
    chk("after_byp_p1", rdata1, 32'h1234_5678);
    chk("after_byp_p2", rdata2, 32'h1234_5678);

    // Bypass to one port while the other reads a different register
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1111;
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    chk("byp_mixed_p1", rdata1, 32'h0000_1111);
    chk("byp_mixed_p2", rdata2, 32'h1234_5678);
    tick();
    we = 1'b0;

    // $zero is never written and never bypassed
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    raddr1 = 5'd0; re1 = 1'b1;
    #1;
    chk("zero_inflight", rdata1, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_after", rdata1, 32'h0);

    // Reset discards a concurrent write
    wr(5'd3, 32'h0000_0099);
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0055;
    raddr1 = 5'd3;
    #1;
    chk("rst_over_byp", rdata1, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    chk("rst_over_wr_r3", rdata1, 32'h0);
    raddr2 = 5'd5;
    #1;
    chk("rst_cleared_r5", rdata2, 32'h0);

`ifdef REGFILE_DBG_PORT_EN
    chk("dbg_cnt_reset", dbg_wr_cnt, 32'h0);
    wr(5'd1, 32'h1);
    wr(5'd0, 32'h2);
    wr(5'd2, 32'h3);
    wr(5'd31, 32'h0000_CAFE);
    wr(5'd4, 32'h5);
    wr(5'd0, 32'h6);
    wr(5'd6, 32'h7);
    wr(5'd8, 32'h8);
    wr(5'd9, 32'h9);
    wr(5'd10, 32'hA);
    dbg_raddr = 5'd31;
    #1;
    chk("dbg_cnt_8", dbg_wr_cnt, 32'd8);
    chk("dbg_rd_r31", dbg_rdata, 32'h0000_CAFE);
    we = 1'b1; waddr = 5'd31; wdata = 32'h0000_BEEF;
    #1;
    chk("dbg_byp", dbg_rdata, 32'h0000_BEEF);
    tick();
    we = 1'b0;
    dbg_raddr = 5'd0;
    #1;
    chk("dbg_zero", dbg_rdata, 32'h0);
    chk("dbg_cnt_9", dbg_wr_cnt, 32'd9);
    force dut.dbg_wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.dbg_wr_cnt_q;
    #1;
    chk("dbg_cnt_forced", dbg_wr_cnt, 32'hFFFF_FFFF);
    wr(5'd12, 32'h12);
    chk("dbg_cnt_wrap", dbg_wr_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file at the end of the integer pipeline.
- The write port consumes the writeback triple (wd, wreg, wdata) produced by the memory-access stage and registered through the MEM/WB boundary.
- The two read ports feed the decode stage.
- Provides same-cycle write-to-read bypass so decode never sees stale data from an instruction retiring in the same cycle.

Parameters:
- NUM_REGS, 32, number of architectural registers; power of two; index width = log2(NUM_REGS).
- DATA_W, 32, register width; matches RegBus.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  write enable (wreg from MEM/WB).
- waddr  input  5  write register index (wd from MEM/WB).
- wdata  input  32  write data.
- re1  input  1  read-port-1 enable.
- raddr1  input  5  read-port-1 index.
- rdata1  output  32  read-port-1 data (combinational).
- re2  input  1  read-port-2 enable.
- raddr2  input  5  read-port-2 index.
- rdata2  output  32  read-port-2 data (combinational).

Behaviour:
- Storage: array regs[0..31] of 32 bits; the only sequential state.
- Reset: on the clk edge with rst=1, all 32 entries clear to 0x00000000.
  - While rst=1, rdata1 and rdata2 = 0x00000000 regardless of other inputs.
  - A write presented in the same cycle as rst=1 is discarded.
- Write: on the rising edge with rst=0, we=1 and waddr!=0, regs[waddr] <= wdata.
  - Writes to index 0 are ignored; regs[0] reads as 0 forever.
- Read port n, combinational, priority order:
  - rst=1 -> 0.
  - raddrn=0 -> 0, even if a write to 0 is in flight.
  - ren=1, we=1, raddrn==waddr -> wdata (bypass, zero-cycle latency).
  - ren=1 -> regs[raddrn].
  - ren=0 -> 0.
- Both ports may read the same index simultaneously; both may hit the bypass in the same cycle.
- Read latency is 0 cycles. Write-to-architectural-state latency is 1 edge; the value is visible via bypass in the write cycle.
- No X propagation: with rst=0, all reads return defined array contents.
- Reset mid-stream: reset wipes state; the pipeline is responsible for not retiring in that cycle.

Optional Feature:
- Macro REGFILE_DBG_PORT_EN.
- When defined:
  - Adds inputs dbg_raddr (5) and outputs dbg_rdata (32): an always-enabled third read port with identical bypass/zero/reset rules.
  - Adds output dbg_wr_cnt (32): counts committed writes (we=1, waddr!=0, rst=0).
    - Resets to 0 and wraps 0xFFFFFFFF -> 0.
- When undefined:
  - These ports do not exist; no counter logic.

Decomposition:
- Shared defines package holds:
  - RstEnable / WriteEnable / ReadEnable / ChipEnable literals.
  - ZeroWord, NOPRegAddr.
  - RegAddrBus (4:0), RegBus (31:0), RegNum (32), RegNumLog2 (5).
- Natural sub-module: regfile_rd_port, one combinational read port containing the zero/bypass/enable mux.
  - Instantiated twice, three times with REGFILE_DBG_PORT_EN.
- The array and write logic stay in regfile.

Test Plan:
- Reset clear:
  - Preload regs 1..31 with 0xA5A5_0000+i.
  - Assert rst one cycle; read all indices on both ports -> 0x00000000 everywhere.
- Basic write/read:
  - Write 0xDEADBEEF to r5; next cycle raddr1=5, re1=1 -> rdata1=0xDEADBEEF.
  - Same cycle re2=0 -> rdata2=0.
- Bypass:
  - Same cycle we=1, waddr=7, wdata=0x12345678, raddr1=raddr2=7, re1=re2=1 -> both rdata=0x12345678 combinationally.
  - Next cycle without write -> still 0x12345678.
- $zero:
  - we=1, waddr=0, wdata=0xFFFFFFFF with raddr1=0 -> rdata1=0 in that cycle and after.
- Reset overrides write:
  - rst=1, we=1, waddr=3, wdata=0x55; next cycle rst=0, read r3 -> 0.
- Debug (REGFILE_DBG_PORT_EN):
  - 10 writes including 2 to r0 -> dbg_wr_cnt=8; dbg_raddr=31 after writing 0xCAFE to r31 -> dbg_rdata=0xCAFE.
  - Force the counter to 0xFFFFFFFF, then one commit -> 0.
